// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared types and helpers for the stream multiplexer/arbiter.
//   mux_mode_e : selection mode (fixed select or round-robin)
//   rr_next    : next round-robin start index, wrapping at n (any n >= 1)
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Compare-and-wrap instead of a true modulo so non-power-of-two channel
  // counts wrap cleanly back to channel 0 without a divider.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter that owns the rotating priority pointer.
// Ports:
//   clk         : rising-edge clock
//   arst        : asynchronous reset, active-low (pointer returns to 0)
//   req         : per-channel request vector
//   advance     : a grant was consumed this cycle; move the pointer past it
//   grant_valid : at least one request is present
//   grant_idx   : winning channel, first request at or after the pointer
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_INPUTS = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic                  advance,
  output logic                  grant_valid,
  output logic [SEL_WIDTH-1:0]  grant_idx
);

  logic [SEL_WIDTH-1:0] rr_ptr;
  int                   cand;
  int unsigned          ptr_next;

  // Walk the channels starting at the pointer, ascending with wrap, and
  // latch onto the first requester. The candidate index is wrapped by a
  // subtraction so it stays legal when NUM_INPUTS is not a power of two.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end
      if (!grant_valid && req[cand[SEL_WIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SEL_WIDTH-1:0];
      end
    end
  end

  // Next pointer sits just past the current winner.
  always_comb begin
    ptr_next = rr_next(32'(grant_idx), NUM_INPUTS);
  end

  // The pointer only moves when the winner actually transferred, so a
  // stalled output never costs a channel its turn.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= ptr_next[SEL_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
// N-to-1 valid/ready stream multiplexer with a single registered output
// stage. The source is picked either by a fixed select field or by
// round-robin arbitration among the valid inputs.
// Ports:
//   clk, arst : rising-edge clock, asynchronous active-low reset
//   i_mode    : 0 = fixed select (i_sel), 1 = round-robin
//   i_sel     : channel index used in fixed mode (out of range grants nothing)
//   i_valid   : per-channel valid
//   i_data    : packed channel data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_ready   : per-channel ready, combinational, at most one bit set
//   o_valid   : registered output valid
//   o_data    : registered output word
//   o_src     : registered index of the channel that produced o_data
//   i_ready   : downstream ready
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_INPUTS = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             i_mode,
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_INPUTS-1:0]            o_ready,
  output logic                             o_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [SEL_WIDTH-1:0]             o_src,
  input  logic                             i_ready
);

  mux_mode_e            mode;
  logic                 load_en;
  logic                 fixed_valid;
  logic                 rr_valid;
  logic [SEL_WIDTH-1:0] rr_idx;
  logic                 grant_valid;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 transfer;
  logic [DATA_WIDTH-1:0] chan [NUM_INPUTS];

  assign mode    = mux_mode_e'(i_mode);
  // The output register can take a word when it is empty or draining.
  assign load_en = !o_valid || i_ready;
  // A grant always points at a valid channel, so load_en plus a grant is
  // exactly one input-side handshake.
  assign transfer = load_en && grant_valid;

  // Unpack the flat data bus so the selected channel is a plain array read.
  always_comb begin
    for (int k = 0; k < NUM_INPUTS; k++) begin
      chan[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Fixed-mode request: selects beyond the channel count are simply idle,
  // which matters when NUM_INPUTS is not a power of two.
  always_comb begin
    fixed_valid = 1'b0;
    if (32'(i_sel) < NUM_INPUTS) begin
      fixed_valid = i_valid[i_sel];
    end
  end

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_arb (
    .clk         (clk),
    .arst        (arst),
    .req         (i_valid),
    .advance     (transfer && (mode == MODE_RR)),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // Mode picks which grant source drives the handshake; changing mode only
  // affects the next evaluation, never the word already registered.
  always_comb begin
    if (mode == MODE_RR) begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = fixed_valid;
      grant_idx   = i_sel;
    end
  end

  // Ready is one-hot on the granted channel and only while the output can load.
  always_comb begin
    o_ready = '0;
    if (transfer) begin
      o_ready[grant_idx] = 1'b1;
    end
  end

  // Output stage: on a load cycle take the granted word, or go empty while
  // keeping the last data/source visible. When stalled everything holds.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
    end else if (load_en) begin
      o_valid <= transfer;
      if (transfer) begin
        o_data <= chan[grant_idx];
        o_src  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb
// Self-checking bench for stream_mux_arb. The 8-channel instance is tracked
// by a transaction-level model; 6- and 5-channel instances cover the
// out-of-range select and non-power-of-two wrap cases.
module tb_stream_mux_arb;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         mode = 1'b0;
  logic [2:0]   sel = '0;
  logic         iready = 1'b1;

  logic [7:0]   v8 = '0;
  logic [255:0] d8 = '0;
  logic [7:0]   r8;
  logic         ov8;
  logic [31:0]  od8;
  logic [2:0]   os8;

  logic [5:0]   v6 = '0;
  logic [191:0] d6 = '0;
  logic [5:0]   r6;
  logic         ov6;
  logic [31:0]  od6;
  logic [2:0]   os6;

  logic [4:0]   v5 = '0;
  logic [159:0] d5 = '0;
  logic [4:0]   r5;
  logic         ov5;
  logic [31:0]  od5;
  logic [2:0]   os5;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level view of the 8-channel output stage and rotation point.
  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_ptr;

  always #5 clk = ~clk;

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_INPUTS(8)) dut8 (
    .clk(clk), .arst(arst), .i_mode(mode), .i_sel(sel), .i_valid(v8), .i_data(d8),
    .o_ready(r8), .o_valid(ov8), .o_data(od8), .o_src(os8), .i_ready(iready)
  );

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_INPUTS(6)) dut6 (
    .clk(clk), .arst(arst), .i_mode(mode), .i_sel(sel), .i_valid(v6), .i_data(d6),
    .o_ready(r6), .o_valid(ov6), .o_data(od6), .o_src(os6), .i_ready(iready)
  );

  stream_mux_arb #(.DATA_WIDTH(32), .NUM_INPUTS(5)) dut5 (
    .clk(clk), .arst(arst), .i_mode(mode), .i_sel(sel), .i_valid(v5), .i_data(d5),
    .o_ready(r5), .o_valid(ov5), .o_data(od5), .o_src(os5), .i_ready(iready)
  );

  // Which channel the rules say wins right now, or -1 for none.
  function automatic int model_pick();
    int k;
    if (mode == 1'b0) begin
      if (int'(sel) < 8 && v8[sel]) return int'(sel);
      return -1;
    end
    for (int s = 0; s < 8; s++) begin
      k = (m_ptr + s) % 8;
      if (v8[k[2:0]]) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_ready();
    logic [7:0] r;
    int g;
    r = '0;
    g = model_pick();
    if ((!m_valid || iready) && g >= 0) r[g[2:0]] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    int g;
    bit load;
    logic [31:0] w;
    g    = model_pick();
    load = !m_valid || iready;
    w    = (g >= 0) ? d8[g*32 +: 32] : 32'h0;
    @(posedge clk);
    if (!arst) begin
      model_reset();
    end else if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = w;
        m_src   = g;
        if (mode) m_ptr = (g + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2 arst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (ov8 !== 1'b0 || od8 !== 32'h0 || os8 !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_init: got v=%b d=%h s=%0d expected v=0 d=0 s=0", ov8, od8, os8);
    end
    repeat (2) tick();
    @(negedge clk) arst = 1'b1;
    mode = 1'b1; iready = 1'b1; v8 = 8'hFF;
    for (int k = 0; k < 8; k++) d8[k*32 +: 32] = 32'hB0 + k;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (r8 !== model_ready()) begin
        miscompares++;
        $display("[TB] FAIL reset_stream_ready: got %b expected %b", r8, model_ready());
      end
      tick();
      vectors++;
      if (ov8 !== m_valid || od8 !== m_data || os8 !== 3'(m_src)) begin
        miscompares++;
        $display("[TB] FAIL reset_stream_out: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                 ov8, od8, os8, m_valid, m_data, m_src);
      end
    end
    arst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (ov8 !== 1'b0 || od8 !== 32'h0 || os8 !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got v=%b d=%h s=%0d expected v=0 d=0 s=0", ov8, od8, os8);
    end
    #3 arst = 1'b1;
    #1;
    vectors++;
    if (r8 !== 8'b0000_0001) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: got %b expected 00000001", r8);
    end
    tick();
    vectors++;
    if (ov8 !== 1'b1 || os8 !== 3'd0 || od8 !== 32'hB0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_out: got v=%b d=%h s=%0d expected v=1 d=b0 s=0", ov8, od8, os8);
    end
  endtask

  task automatic test_fixed_basic();
    mode = 1'b0; sel = 3'd5; iready = 1'b1; v8 = 8'hFF;
    for (int k = 0; k < 8; k++) d8[k*32 +: 32] = 32'hA0 + k;
    #1;
    vectors++;
    if (r8 !== 8'b0010_0000 || r8 !== model_ready()) begin
      miscompares++;
      $display("[TB] FAIL fixed_ready: got %b expected 00100000", r8);
    end
    tick();
    vectors++;
    if (ov8 !== 1'b1 || od8 !== 32'hA5 || os8 !== 3'd5 || od8 !== m_data) begin
      miscompares++;
      $display("[TB] FAIL fixed_out: got v=%b d=%h s=%0d expected v=1 d=a5 s=5", ov8, od8, os8);
    end
  endtask

  task automatic test_fixed_out_of_range();
    v8 = '0; mode = 1'b0; sel = 3'd2; iready = 1'b1; v6 = 6'h3F;
    for (int k = 0; k < 6; k++) d6[k*32 +: 32] = 32'hC0 + k;
    #1;
    vectors++;
    if (r6 !== 6'b00_0100) begin
      miscompares++;
      $display("[TB] FAIL oor_load_ready: got %b expected 000100", r6);
    end
    tick();
    vectors++;
    if (ov6 !== 1'b1 || od6 !== 32'hC2 || os6 !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL oor_load_out: got v=%b d=%h s=%0d expected v=1 d=c2 s=2", ov6, od6, os6);
    end
    sel = 3'd7; iready = 1'b0;
    #1;
    vectors++;
    if (r6 !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_stall_ready: got %b expected 000000", r6);
    end
    tick();
    vectors++;
    if (ov6 !== 1'b1 || od6 !== 32'hC2 || os6 !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL oor_hold: got v=%b d=%h s=%0d expected v=1 d=c2 s=2", ov6, od6, os6);
    end
    iready = 1'b1;
    #1;
    vectors++;
    if (r6 !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_drain_ready: got %b expected 000000", r6);
    end
    tick();
    vectors++;
    if (ov6 !== 1'b0 || od6 !== 32'hC2 || os6 !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL oor_drain: got v=%b d=%h s=%0d expected v=0 d=c2 s=2", ov6, od6, os6);
    end
    v6 = '0;
  endtask

  task automatic test_rr_fairness();
    int seq [4];
    seq = '{0, 2, 5, 7};
    arst = 1'b0;
    #1 arst = 1'b1;
    model_reset();
    mode = 1'b1; iready = 1'b1; v8 = 8'b1010_0101;
    for (int k = 0; k < 8; k++) d8[k*32 +: 32] = 32'h10 + k;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if (r8 !== model_ready()) begin
        miscompares++;
        $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", i, r8, model_ready());
      end
      tick();
      vectors++;
      if (ov8 !== 1'b1 || os8 !== 3'(seq[i % 4]) || od8 !== m_data || os8 !== 3'(m_src)) begin
        miscompares++;
        $display("[TB] FAIL rr_seq[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 i, ov8, os8, od8, seq[i % 4], m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; iready = 1'b1; v8 = 8'b0000_1000;
    d8[3*32 +: 32] = 32'h33;
    #1;
    tick();
    d8[3*32 +: 32] = 32'h34;
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (r8 !== 8'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_ready[%0d]: got %b expected 00000000", i, r8);
      end
      tick();
      vectors++;
      if (ov8 !== 1'b1 || od8 !== 32'h33 || os8 !== 3'd3 || dut8.u_arb.rr_ptr !== 3'(m_ptr)) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h s=%0d p=%0d expected v=1 d=33 s=3 p=%0d",
                 i, ov8, od8, os8, dut8.u_arb.rr_ptr, m_ptr);
      end
    end
    iready = 1'b1;
    #1;
    vectors++;
    if (r8 !== 8'b0000_1000) begin
      miscompares++;
      $display("[TB] FAIL bp_release_ready: got %b expected 00001000", r8);
    end
    tick();
    vectors++;
    if (ov8 !== 1'b1 || od8 !== 32'h34 || os8 !== 3'd3 || od8 !== m_data) begin
      miscompares++;
      $display("[TB] FAIL bp_release_out: got v=%b d=%h s=%0d expected v=1 d=34 s=3", ov8, od8, os8);
    end
    v8 = '0;
  endtask

  task automatic test_npot_wrap();
    logic [4:0] exp_rdy [4];
    int         exp_src [4];
    exp_rdy = '{5'b10000, 5'b00001, 5'b10000, 5'b00001};
    exp_src = '{4, 0, 4, 0};
    v8 = '0; mode = 1'b1; iready = 1'b1;
    for (int k = 0; k < 5; k++) d5[k*32 +: 32] = 32'h50 + k;
    for (int i = 0; i < 4; i++) begin
      v5 = (i == 0) ? 5'b10000 : 5'b10001;
      #1;
      vectors++;
      if (r5 !== exp_rdy[i]) begin
        miscompares++;
        $display("[TB] FAIL wrap_ready[%0d]: got %b expected %b", i, r5, exp_rdy[i]);
      end
      tick();
      vectors++;
      if (ov5 !== 1'b1 || os5 !== 3'(exp_src[i]) || od5 !== 32'h50 + 32'(exp_src[i])) begin
        miscompares++;
        $display("[TB] FAIL wrap_src[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d",
                 i, ov5, os5, od5, exp_src[i]);
      end
    end
    vectors++;
    if (dut5.u_arb.rr_ptr !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL wrap_ptr: got %0d expected 1", dut5.u_arb.rr_ptr);
    end
    v5 = '0;
  endtask

  task automatic test_random();
    logic [7:0] r;
    arst = 1'b0;
    #1 arst = 1'b1;
    model_reset();
    v8 = '0;
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) mode = 1'($urandom_range(0, 1));
      sel    = 3'($urandom_range(0, 7));
      iready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) begin
        if (!v8[k] && $urandom_range(0, 1) == 1) begin
          v8[k] = 1'b1;
          d8[k*32 +: 32] = $urandom;
        end
      end
      #1;
      r = model_ready();
      vectors++;
      if (r8 !== r) begin
        miscompares++;
        $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", i, r8, r);
      end
      tick();
      vectors++;
      if (ov8 !== m_valid || od8 !== m_data || os8 !== 3'(m_src)) begin
        miscompares++;
        $display("[TB] FAIL rand_out[%0d]: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                 i, ov8, od8, os8, m_valid, m_data, m_src);
      end
      v8 = v8 & ~r;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed_basic();
    test_fixed_out_of_range();
    test_rr_fairness();
    test_backpressure();
    test_npot_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
